// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and dead-time state encoding for the PWM channel.
package pwm_pkg;
  localparam int PWM_WIDTH = 8;
  localparam int PWM_DT_WIDTH = 4;
  typedef enum logic [1:0] {OFF, HI, LO, DT} pwm_state_e;
endpackage

// File: rtl/pwm_channel_if.sv
// pwm_channel_if: link between the compare stage and the dead-time output stage.
interface pwm_channel_if
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = PWM_DT_WIDTH
);
  logic raw;
  logic enable;
  logic polarity;
  logic pwm_hi;
  logic pwm_lo;
  logic [DT_WIDTH-1:0] deadtime;
  modport master (output raw, enable, deadtime, polarity, input pwm_hi, pwm_lo);
  modport slave (input raw, enable, deadtime, polarity, output pwm_hi, pwm_lo);
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time state machine and registered complementary outputs.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = PWM_DT_WIDTH
) (
  input logic clk,
  input logic rst_n,
  pwm_channel_if.slave bus
);
  pwm_state_e state_q, state_d;
  logic target_q, target_d;
  logic hi_q, hi_d, lo_q, lo_d;
  logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    dt_cnt_d = dt_cnt_q;
    if (!bus.enable) state_d = OFF;
    else
      case (state_q)
        OFF: begin
          state_d = DT;
          target_d = bus.raw;
          dt_cnt_d = bus.deadtime;
        end
        HI, LO:
          if (bus.raw != (state_q == HI)) begin
            state_d = (bus.deadtime == '0) ? (bus.raw ? HI : LO) : DT;
            target_d = bus.raw;
            dt_cnt_d = bus.deadtime;
          end
        default:
          if (bus.raw != target_q) begin
            target_d = bus.raw;
            dt_cnt_d = bus.deadtime;
          end else if (dt_cnt_q <= DT_WIDTH'(1)) state_d = target_q ? HI : LO;
          else dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
      endcase
    hi_d = (state_d == HI) ^ bus.polarity;
    lo_d = (state_d == LO) ^ bus.polarity;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= OFF;
      target_q <= 1'b0;
      dt_cnt_q <= '0;
      hi_q <= 1'b0;
      lo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      dt_cnt_q <= dt_cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  assign bus.pwm_hi = hi_q;
  assign bus.pwm_lo = lo_q;
endmodule

// File: rtl/pwm_channel.sv
// pwm_channel: duty shadowing and compare stage feeding the dead-time output stage.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int DT_WIDTH = PWM_DT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    cnt_i,
  input  logic                enable_i,
  input  logic [WIDTH-1:0]    duty_i,
  input  logic                duty_we_i,
  input  logic                polarity_i,
  input  logic [DT_WIDTH-1:0] deadtime_i,
  output logic                pwm_hi_o,
  output logic                pwm_lo_o,
  output logic                period_o,
  output logic                update_o
);
  logic [WIDTH-1:0] cnt_q, cnt_d, active_q, active_d, pend_q, pend_d;
  logic pend_flag_q, pend_flag_d, raw_q, raw_d, period_q, period_d, update_q, update_d;
  logic boundary, reload;
  always_comb begin
    boundary = (cnt_i == '0) && (cnt_q != '0);
    reload = pend_flag_q && (boundary || !enable_i);
    cnt_d = cnt_i;
    active_d = reload ? pend_q : active_q;
    pend_d = duty_we_i ? duty_i : pend_q;
    pend_flag_d = duty_we_i || (pend_flag_q && !reload);
    raw_d = cnt_i < active_q;
    period_d = boundary;
    update_d = reload;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      active_q <= '0;
      pend_q <= '0;
      pend_flag_q <= 1'b0;
      raw_q <= 1'b0;
      period_q <= 1'b0;
      update_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      active_q <= active_d;
      pend_q <= pend_d;
      pend_flag_q <= pend_flag_d;
      raw_q <= raw_d;
      period_q <= period_d;
      update_q <= update_d;
    end
  pwm_channel_if #(.DT_WIDTH(DT_WIDTH)) dt_if ();
  assign dt_if.raw = raw_q;
  assign dt_if.enable = enable_i;
  assign dt_if.deadtime = deadtime_i;
  assign dt_if.polarity = polarity_i;
  pwm_deadtime #(.DT_WIDTH(DT_WIDTH)) u_deadtime (.clk(clk), .rst_n(rst_n), .bus(dt_if));
  assign pwm_hi_o = dt_if.pwm_hi;
  assign pwm_lo_o = dt_if.pwm_lo;
  assign period_o = period_q;
  assign update_o = update_q;
endmodule

// File: doc/pwm_channel.md
PWM_CHANNEL -- requirements
Module: pwm_channel

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the count input and duty registers.
REQ-002 SHALL have parameter DT_WIDTH, default 4: width of the dead-time setting.
REQ-003 SHALL have the port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have the port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have the port cnt_i, input, WIDTH: free-running period count from the upstream counter.
REQ-006 SHALL have the port enable_i, input, 1: channel enable.
REQ-007 SHALL have the port duty_i, input, WIDTH: new duty value.
REQ-008 SHALL have the port duty_we_i, input, 1: single-cycle write strobe for duty_i.
REQ-009 SHALL have the port polarity_i, input, 1: when 1, both outputs are active-low.
REQ-010 SHALL have the port deadtime_i, input, DT_WIDTH: dead-time length in clk cycles.
REQ-011 SHALL have the port pwm_hi_o, output, 1: high-side drive.
REQ-012 SHALL have the port pwm_lo_o, output, 1: complementary low-side drive.
REQ-013 SHALL have the port period_o, output, 1: one-cycle pulse at each period boundary.
REQ-014 SHALL have the port update_o, output, 1: one-cycle pulse when the active duty is reloaded.

Function
REQ-015 SHALL register cnt_i into cnt_q every cycle; a period boundary is any cycle with cnt_i == 0 and cnt_q != 0.
REQ-016 SHALL, on duty_we_i, capture duty_i into a pending register and set a pending flag; a later write before reload overwrites it (last write wins).
REQ-017 SHALL copy pending into the active duty at a period boundary if the pending flag is set, clear the flag, and pulse update_o in the next cycle.
REQ-018 SHALL, while enable_i is 0, copy pending to active on the cycle after the write, with no wait for a boundary; update_o pulses identically.
REQ-019 SHALL, for a simultaneous duty_we_i and reload in the same cycle, reload the old pending value and keep the new write pending.
REQ-020 SHALL compute the compare result raw = (cnt_i < active duty) and register it as raw_q; duty 0 gives a permanently low raw_q; duty 2^WIDTH-1 gives raw_q low only at count 2^WIDTH-1.
REQ-021 SHALL implement a state machine with states OFF, HI, LO, DT; DT holds a down-counter and a target level.
REQ-022 SHALL go to OFF on the next edge from any state when enable_i == 0.
REQ-023 SHALL, from OFF with enable_i == 1, enter DT with target = raw_q and the counter loaded with deadtime_i.
REQ-024 SHALL, in HI or LO, when raw_q differs from the current level, enter DT with target = raw_q and the counter = deadtime_i; if deadtime_i == 0, go directly to the opposite state instead.
REQ-025 SHALL, in DT, decrement the counter each cycle and enter HI or LO per target when the counter reaches 1 (or is 0).
REQ-026 SHALL, if raw_q changes during DT, replace the target and reload the counter with deadtime_i.
REQ-027 SHALL drive registered outputs, updated on the same edge as the state: pwm_hi_o = (state==HI) XOR polarity_i and pwm_lo_o = (state==LO) XOR polarity_i; both are inactive in OFF and DT.
REQ-028 SHALL never drive both outputs active in the same cycle, for any input sequence.
REQ-029 SHALL, with deadtime_i == 0, give a latency of exactly 2 clk edges from cnt_i to the outputs.
REQ-030 SHALL pulse period_o for one cycle on the edge after a boundary is detected.
REQ-031 SHALL sample deadtime_i only when loading the DT counter; polarity_i takes effect on the next edge.

Reset
REQ-032 SHALL, when rst_n is low, set state OFF, pwm_hi_o = 0, pwm_lo_o = 0, period_o = 0, update_o = 0, active duty = 0, pending = 0, pending flag clear, cnt_q = 0 and raw_q = 0.
REQ-033 SHALL restart from OFF per REQ-023 on reset release mid-period; the outputs remain 0 through the first post-reset cycle.

Structure
REQ-034 SHALL place the state enum (OFF, HI, LO, DT) and the default WIDTH/DT_WIDTH constants in shared package pwm_pkg.
REQ-035 SHALL implement the dead-time state machine and the output registers as sub-module pwm_deadtime (inputs: raw_q, enable, deadtime, polarity); compare and duty shadowing stay in pwm_channel.

Verification
REQ-036 SHALL verify duty 64, deadtime 0, polarity 0, with cnt_i sweeping 0..255 -> pwm_hi_o high for 64 cycles per period, pwm_lo_o the exact complement, edges lagging cnt_i by 2 cycles.
REQ-037 SHALL verify deadtime 3 with duty 128 -> 3-cycle gaps with both outputs 0 at every transition; hi and lo never overlap.
REQ-038 SHALL verify a write of duty 200 at cnt_i = 50 while enabled -> the old duty holds until cnt_i wraps to 0, update_o pulses once, and the new duty applies from that period.
REQ-039 SHALL verify writes of 10 then 20 in one period -> only 20 is loaded at the boundary, with a single update_o pulse.
REQ-040 SHALL verify polarity 1 and duty 0 -> pwm_hi_o constantly 1 (inactive) and pwm_lo_o 0 (active) after enable plus dead-time.
REQ-041 SHALL verify enable_i dropped mid-HI, then rst_n asserted mid-DT -> OFF with both outputs inactive on the next edge, and all outputs 0 immediately on reset.
